risc_v_mike_muldiv_seq: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer for the RV32 core. It implements MUL, MULHU, DIVU and REMU by driving the shared 32-bit ALU through 32 add or subtract iterations: shift-add for multiply, restoring division for divide. It sits beside the execute stage. While `busy` is high, the execute-stage ALU operand mux hands the ALU to this block.

---
 rtl/risc_v_mike_muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_risc_v_mike_muldiv_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mike_muldiv_seq.sv
// Sequential unsigned MUL/MULHU/DIVU/REMU that borrows the execute-stage ALU.
// Define RISC_V_MIKE_MULDIV_DIV_EN to build the divide datapath.
module risc_v_mike_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            busy,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  output logic [2:0]      alu_ctrl,
  output logic            alu_signed,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_slt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [4:0]      cnt;
  logic [1:0]      op;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mcand;
  logic            accept;
  logic            carry;

  assign accept = req_valid && req_ready;
  assign carry  = alu_result < hi;

`ifdef RISC_V_MIKE_MULDIV_DIV_EN
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] r_sh;
  logic            ovf;
  logic            take;

  assign r_sh = {rem[XLEN-2:0], quo[XLEN-1]};
  assign ovf  = rem[XLEN-1];
  assign take = ovf || !alu_slt;
`else
  logic unused_slt;
  assign unused_slt = alu_slt;
`endif

  assign req_ready = state == IDLE;
  assign busy      = state == RUN;
  assign rsp_valid = state == DONE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
          state_nx = RUN;
`else
          state_nx = req_op[1] ? DONE : RUN;
`endif
        end
      end
      RUN:  if (cnt == 5'd31) state_nx = DONE;
      DONE: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  always_comb begin
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_ctrl   = ALU_ADD;
    alu_signed = 1'b0;
    if (state == RUN) begin
      if (!op[1]) begin
        alu_src_a = hi;
        alu_src_b = mcand;
        alu_ctrl  = ALU_ADD;
      end
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
      else begin
        alu_src_a = r_sh;
        alu_src_b = dvsr;
        alu_ctrl  = ALU_SUB;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      op    <= OP_MUL;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
`endif
    end else if (state == IDLE && accept && !kill) begin
      op  <= req_op;
      cnt <= '0;
      if (!req_op[1]) begin
        hi    <= '0;
        lo    <= req_b;
        mcand <= req_a;
      end
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
      else begin
        rem  <= '0;
        quo  <= req_a;
        dvsr <= req_b;
      end
`endif
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      if (!op[1]) begin
        // shift-add: the 33-bit partial sum shifts right into lo
        if (lo[0]) begin
          hi <= {carry, alu_result[XLEN-1:1]};
          lo <= {alu_result[0], lo[XLEN-1:1]};
        end else begin
          hi <= {1'b0, hi[XLEN-1:1]};
          lo <= {hi[0], lo[XLEN-1:1]};
        end
      end
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
      else begin
        // restoring step; ovf covers a shifted remainder wider than 32 bits
        rem <= take ? alu_result : r_sh;
        quo <= {quo[XLEN-2:0], take};
      end
`endif
    end
  end

  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (state == DONE) begin
      unique case (1'b1)
        op == OP_MUL:   rsp_data = lo;
        op == OP_MULHU: rsp_data = hi;
`ifdef RISC_V_MIKE_MULDIV_DIV_EN
        op == OP_DIVU:  rsp_data = quo;
        op == OP_REMU:  rsp_data = rem;
`else
        op[1]: begin
          rsp_data = 32'hDEADBEEF;
          rsp_err  = 1'b1;
        end
`endif
        default: rsp_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_muldiv_seq.sv
// Scoreboard bench for risc_v_mike_muldiv_seq with a behavioural ALU.
// Expectations follow RISC_V_MIKE_MULDIV_DIV_EN as compiled.
module tb_risc_v_mike_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        kill;
  logic        busy;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [2:0]  alu_ctrl;
  logic        alu_signed;
  logic [31:0] alu_result;
  logic        alu_slt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  risc_v_mike_muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .kill       (kill),
    .busy       (busy),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .alu_signed (alu_signed),
    .alu_result (alu_result),
    .alu_slt    (alu_slt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always_comb begin
    alu_result = (alu_ctrl == 3'd1) ? alu_src_a - alu_src_b
                                    : alu_src_a + alu_src_b;
    alu_slt = alu_src_a < alu_src_b;
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

`ifdef RISC_V_MIKE_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic exp_t div_exp(input logic [31:0] v);
    exp_t e;
    e.data = DIV_EN ? v : 32'hDEADBEEF;
    e.err  = !DIV_EN;
    return e;
  endfunction

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic [63:0] p;
    exp_t e;
    p = {32'd0, a} * {32'd0, b};
    e.err = 1'b0;
    case (op)
      2'd0:    e.data = p[31:0];
      2'd1:    e.data = p[63:32];
      2'd2:    e.data = (b == 0) ? 32'hFFFFFFFF : a / b;
      default: e.data = (b == 0) ? a : a % b;
    endcase
    if (op[1]) e = div_exp(e.data);
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e,
                        input int hold);
    int   lat;
    int   busy_n;
    int   rdy_seen;
    int   unstable;
    int   exp_lat;
    int   w;
    logic [31:0] d0;
    exp_t got;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    exp_lat = (op[1] && !DIV_EN) ? 0 : 32;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_accept: got %b want 1", req_ready);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    busy_n = 0;
    rdy_seen = 0;
    while (!rsp_valid && lat < 100) begin
      if (busy) busy_n++;
      if (req_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL latency op%0d: got %0d want %0d", op, lat, exp_lat);
    end
    checks++;
    if (busy_n != exp_lat) begin
      errors++;
      $display("FAIL busy_cycles op%0d: got %0d want %0d",
               op, busy_n, exp_lat);
    end
    checks++;
    if (rdy_seen != 0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_ready_low op%0d: got %0d high cycles want 0",
               op, rdy_seen + int'(req_ready));
    end
    if (sb.size() > 0) got = sb.pop_front();
    else got = '0;
    checks++;
    if (rsp_data !== got.data || rsp_err !== got.err) begin
      errors++;
      $display("FAIL rsp op%0d a=%h b=%h: got %h/%b want %h/%b",
               op, a, b, rsp_data, rsp_err, got.data, got.err);
    end
    d0 = rsp_data;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0) unstable++;
    end
    if (hold > 0) begin
      checks++;
      if (unstable != 0) begin
        errors++;
        $display("FAIL hold_stable: got %0d unstable cycles want 0",
                 unstable);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        alu_src_a !== 0 || alu_src_b !== 0 || alu_ctrl !== 0) begin
      errors++;
      $display("FAIL after_handshake: got rdy=%b vld=%b busy=%b a=%h b=%h c=%0d want 1 0 0 0 0 0",
               req_ready, rsp_valid, busy, alu_src_a, alu_src_b, alu_ctrl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_a = '0;
    req_b = '0;
    kill = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_data !== 0 || alu_src_a !== 0 ||
        alu_src_b !== 0 || alu_ctrl !== 0 || alu_signed !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b busy=%b vld=%b err=%b d=%h want 1 0 0 0 0",
               req_ready, busy, rsp_valid, rsp_err, rsp_data);
    end
  endtask

  task automatic test_mul();
    run_op(2'd0, 32'd7, 32'd6, exp_t'({32'h0000002A, 1'b0}), 0);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           exp_t'({32'hFFFFFFFE, 1'b0}), 0);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           exp_t'({32'h00000001, 1'b0}), 0);
  endtask

  task automatic test_div();
    run_op(2'd2, 32'd100, 32'd7, div_exp(32'd14), 0);
    run_op(2'd3, 32'd100, 32'd7, div_exp(32'd2), 0);
    run_op(2'd2, 32'h1234, 32'd0, div_exp(32'hFFFFFFFF), 0);
    run_op(2'd3, 32'h1234, 32'd0, div_exp(32'h1234), 0);
    run_op(2'd2, 32'd9, 32'd3, div_exp(32'd3), 0);
    run_op(2'd2, 32'hFFFFFFFF, 32'h80000001, div_exp(32'd1), 0);
    run_op(2'd3, 32'hFFFFFFFF, 32'h80000001, div_exp(32'h7FFFFFFE), 0);
  endtask

  task automatic test_hold();
    run_op(2'd1, 32'h12345678, 32'h9ABCDEF0,
           model(2'd1, 32'h12345678, 32'h9ABCDEF0), 5);
  endtask

  task automatic test_kill();
    int late;
    req_valid = 1'b1;
    req_op = 2'd0;
    req_a = 32'h1234;
    req_b = 32'h5678;
    sb.push_back(model(2'd0, 32'h1234, 32'h5678));
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL kill_pre_busy: got %b want 1", busy);
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    // the aborted op never responds, so its entry is retired here
    void'(sb.pop_back());
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        alu_src_a !== 0 || alu_src_b !== 0 || alu_ctrl !== 0) begin
      errors++;
      $display("FAIL kill_idle: got busy=%b rdy=%b vld=%b a=%h b=%h want 0 1 0 0 0",
               busy, req_ready, rsp_valid, alu_src_a, alu_src_b);
    end
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL kill_no_rsp: got %0d valid cycles want 0", late);
    end
    run_op(2'd0, 32'd3, 32'd5, exp_t'({32'd15, 1'b0}), 0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a = $urandom;
      b = (i == 6) ? 32'd0 : $urandom >> (i % 3) * 8;
      run_op(op, a, b, model(op, a, b), 0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_kill();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
